// File: rtl/unit_forward_sb_pkg.sv
// Shared types and constants for the scoreboard forwarding unit.
package pkg_fwd;

   // Typical producer latencies (stage at which the result can be forwarded)
   localparam int LAT_ALU  = 1;
   localparam int LAT_LOAD = 2;
   localparam int LAT_MUL  = 3;

   // Forward select value meaning "take the operand from the register file"
   localparam int FWD_RF = 0;

   // Storage widths of a scoreboard entry; sized to cover any supported REGW/LATW
   localparam int RD_W  = 8;
   localparam int CNT_W = 8;

   typedef struct packed {
      logic             v;
      logic [RD_W-1:0]  rd;
      logic [CNT_W-1:0] cnt;
   } fwd_entry_t;

endpackage

// File: rtl/unit_forward_sb_if.sv
// EX-stage request / forwarding response bundle of the forwarding unit.
interface unit_forward_sb_if #(
   parameter int REGW   = 5,
   parameter int NSRC   = 2,
   parameter int NSTAGE = 3,
   parameter int SELW   = $clog2(NSTAGE + 1),
   parameter int LATW   = $clog2(NSTAGE + 1)
);
   logic                   ex_valid;
   logic                   ex_regwrite;
   logic [REGW-1:0]        ex_rd;
   logic [LATW-1:0]        ex_lat;
   logic [NSRC*REGW-1:0]   ex_rs;
   logic                   hold;
   logic                   flush;
   logic [NSRC*SELW-1:0]   fwd_sel;
   logic                   stall;
   logic [15:0]            stall_cnt;

   modport master (
      output ex_valid, ex_regwrite, ex_rd, ex_lat, ex_rs, hold, flush,
      input  fwd_sel, stall, stall_cnt
   );

   modport slave (
      input  ex_valid, ex_regwrite, ex_rd, ex_lat, ex_rs, hold, flush,
      output fwd_sel, stall, stall_cnt
   );
endinterface

// File: rtl/unit_forward_sb_match.sv
// Priority match of one source operand against all scoreboard stages.
// The youngest (lowest-numbered) matching stage decides: forward if ready, stall if not.
module unit_forward_sb_match
   import pkg_fwd::*;
#(
   parameter int REGW   = 5,
   parameter int NSTAGE = 3,
   parameter int SELW   = $clog2(NSTAGE + 1)
) (
   input  logic [REGW-1:0]        rs,
   input  logic [NSTAGE-1:0]      stgV,
   input  logic [NSTAGE-1:0]      stgRdy,
   input  logic [NSTAGE*RD_W-1:0] stgRd,
   output logic [SELW-1:0]        sel,
   output logic                   needStall
);
   logic found;

   // scan from youngest to oldest, first hit wins even if an older entry is ready
   always_comb begin
      sel       = SELW'(FWD_RF);
      needStall = 1'b0;
      found     = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
         if (!found && (rs != '0) && stgV[k] && (stgRd[k*RD_W +: RD_W] == RD_W'(rs))) begin
            found = 1'b1;
            if (stgRdy[k]) sel = SELW'(k + 1);
            else           needStall = 1'b1;
         end
      end
   end
endmodule

// File: rtl/unit_forward_sb.sv
// Scoreboard-based forwarding and stall unit: tracks in-flight writers across
// NSTAGE post-EX stages with a remaining-latency count per entry.
module unit_forward_sb
   import pkg_fwd::*;
#(
   parameter int REGW   = 5,
   parameter int NSRC   = 2,
   parameter int NSTAGE = 3,
   parameter int SELW   = $clog2(NSTAGE + 1),
   parameter int LATW   = $clog2(NSTAGE + 1)
) (
   input logic              clk,
   input logic              reset_n,
   unit_forward_sb_if.slave bus
);
   fwd_entry_t             stg [1:NSTAGE];
   logic [NSTAGE-1:0]      stgV;
   logic [NSTAGE-1:0]      stgRdy;
   logic [NSTAGE*RD_W-1:0] stgRd;
   logic [NSRC-1:0]        needStall;
   logic [NSRC*SELW-1:0]   fwdSel;
   logic [LATW-1:0]        latEff;
   logic                   stallInt;
   logic                   loadEntry;
   logic [15:0]            stallCnt;

   // flatten stage contents for the per-operand matchers
   always_comb begin
      stgV   = '0;
      stgRdy = '0;
      stgRd  = '0;
      for (int k = 1; k <= NSTAGE; k++) begin
         stgV[k-1]                   = stg[k].v;
         stgRdy[k-1]                 = (stg[k].cnt == '0);
         stgRd[(k-1)*RD_W +: RD_W]   = stg[k].rd;
      end
   end

   for (genvar i = 0; i < NSRC; i++) begin : gMatch
      unit_forward_sb_match #(
         .REGW   (REGW),
         .NSTAGE (NSTAGE),
         .SELW   (SELW)
      ) uMatch (
         .rs        (bus.ex_rs[i*REGW +: REGW]),
         .stgV      (stgV),
         .stgRdy    (stgRdy),
         .stgRd     (stgRd),
         .sel       (fwdSel[i*SELW +: SELW]),
         .needStall (needStall[i])
      );
   end

   // a zero latency is treated as ALU, anything past the last stage as the last stage
   always_comb begin
      if (bus.ex_lat == '0)                latEff = LATW'(1);
      else if (bus.ex_lat > LATW'(NSTAGE)) latEff = LATW'(NSTAGE);
      else                                 latEff = bus.ex_lat;
   end

   assign stallInt  = (|needStall) & bus.ex_valid & ~bus.flush;
   assign loadEntry = bus.ex_valid & bus.ex_regwrite & (bus.ex_rd != '0) & ~bus.flush & ~stallInt;

   // shift the scoreboard one stage per unfrozen cycle; counts age toward ready
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 1; k <= NSTAGE; k++) stg[k] <= '0;
      end else if (!bus.hold) begin
         stg[1].v   <= loadEntry;
         stg[1].rd  <= loadEntry ? RD_W'(bus.ex_rd) : '0;
         stg[1].cnt <= loadEntry ? CNT_W'(latEff - LATW'(1)) : '0;
         for (int k = 2; k <= NSTAGE; k++) begin
            stg[k].v   <= stg[k-1].v;
            stg[k].rd  <= stg[k-1].rd;
            stg[k].cnt <= (stg[k-1].cnt == '0) ? '0 : stg[k-1].cnt - CNT_W'(1);
         end
      end
   end

   // saturating count of cycles actually lost to stalls (frozen cycles excluded)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                          stallCnt <= '0;
      else if (stallInt && !bus.hold && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
   end

   assign bus.fwd_sel   = fwdSel;
   assign bus.stall     = stallInt;
   assign bus.stall_cnt = stallCnt;
endmodule
